afe2256_lvds_tx: RTL

Bit-serial transmitter that emulates the AFE2256 ROIC LVDS output: DCLK, FCLK and DOUT, single-ended and pre-OBUFDS. It frames 12-bit pixels plus a 12-bit alignment vector into 24-bit DDR words, using the same word format, sync pattern and line length that the receive-side ISERDES deserializer expects. It sits in the loopback/bring-up path, driving the deserializer inputs through OBUFDS so alignment and capture can be exercised without a ROIC attached.

---
 rtl/afe2256_lvds_pkg.sv | 23 ++
 rtl/afe2256_lvds_tx_if.sv | 11 +
 rtl/afe2256_lvds_ser24.sv | 41 ++++
 rtl/afe2256_lvds_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/afe2256_lvds_pkg.sv
// Shared word format, sync/test patterns and state type for the AFE2256 LVDS emulator.
// Optional feature macro used by the transmitter: AFE2256_TX_TEST_PATTERN_EN.
package afe2256_lvds_pkg;

    localparam int PIXEL_WIDTH = 12;
    localparam int ALIGN_WIDTH = 12;
    localparam int TOTAL_WIDTH = PIXEL_WIDTH + ALIGN_WIDTH;
    localparam int LINE_PIXELS = 256;

    localparam logic [PIXEL_WIDTH-1:0] SYNC_PATTERN_HIGH = 12'hFFF;
    localparam logic [ALIGN_WIDTH-1:0] SYNC_PATTERN_LOW  = 12'h000;
    localparam logic [PIXEL_WIDTH-1:0] ROW_PATTERN       = 12'hAAA;
    localparam logic [PIXEL_WIDTH-1:0] COL_PATTERN       = 12'h555;
    localparam logic [1:0]             ALIGN_PREFIX      = 2'b10;

    typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_GAP} tx_state_t;

    function automatic logic [ALIGN_WIDTH-1:0] align_vector(input logic sol, input logic eol,
                                                            input logic [7:0] idx);
        return {ALIGN_PREFIX, sol, eol, idx};
    endfunction

endpackage

// File: rtl/afe2256_lvds_tx_if.sv
// Pixel stream handshake into the LVDS transmitter.
interface afe2256_lvds_tx_if;
    import afe2256_lvds_pkg::*;

    logic                   valid;
    logic [PIXEL_WIDTH-1:0] pixel;
    logic                   ready;

    modport master (output valid, output pixel, input ready);
    modport slave  (input valid, input pixel, output ready);
endinterface

// File: rtl/afe2256_lvds_ser24.sv
// 24-bit load-and-shift serializer with free-running bit counter; MSB leaves first.
module afe2256_lvds_ser24
    import afe2256_lvds_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [TOTAL_WIDTH-1:0] word,
    output logic [4:0]             bit_cnt,
    output logic                   word_end,
    output logic                   dout
);

    logic [TOTAL_WIDTH-1:0] shreg_reg;
    logic [TOTAL_WIDTH-1:0] shreg_next;
    logic [4:0]             bit_cnt_reg;

    assign word_end = (bit_cnt_reg == 5'd23);
    assign bit_cnt  = bit_cnt_reg;
    assign dout     = shreg_reg[TOTAL_WIDTH-1];

    // Without a load at the wrap the register refills with zeros (idle line).
    assign shreg_next[0] = word_end & load & word[0];
    genvar gi;
    generate
        for (gi = 1; gi < TOTAL_WIDTH; gi++) begin : g_shift
            assign shreg_next[gi] = word_end ? (load & word[gi]) : shreg_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= word_end ? 5'd0 : bit_cnt_reg + 5'd1;
        end
    end

endmodule

// File: rtl/afe2256_lvds_tx.sv
// AFE2256 ROIC LVDS output emulator: frames pixels + align vectors into DDR words.
// Optional AFE2256_TX_TEST_PATTERN_EN adds test_mode (AAA/555 line patterns).
module afe2256_lvds_tx #(
    parameter int LINE_PIXELS = afe2256_lvds_pkg::LINE_PIXELS,
    parameter int NUM_LINES   = 4,
    parameter int SYNC_WORDS  = 4,
    parameter int GAP_WORDS   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef AFE2256_TX_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    afe2256_lvds_tx_if.slave s,
    output logic dclk,
    output logic fclk,
    output logic dout,
    output logic busy,
    output logic line_done,
    output logic frame_done,
    output logic underflow
);
    import afe2256_lvds_pkg::*;

    localparam logic [15:0] LP_LAST    = 16'(LINE_PIXELS - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_WORDS - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_WORDS - 1);
    localparam logic [15:0] LINES_LAST = 16'(NUM_LINES - 1);

    tx_state_t              state_reg, state_next;
    logic [15:0]            word_cnt_reg, word_cnt_next;
    logic [15:0]            line_cnt_reg, line_cnt_next;
    logic                   req_reg, busy_reg, dclk_reg, fclk_reg, s_ready_reg;
    logic                   line_done_reg, frame_done_reg, underflow_reg;
    logic                   line_end, last_line, ready_set;
    logic [PIXEL_WIDTH-1:0] pixel_next;
    logic [TOTAL_WIDTH-1:0] word_next;
    logic [4:0]             bit_cnt;
    logic                   word_end;
`ifdef AFE2256_TX_TEST_PATTERN_EN
    logic                   tm_reg;
`endif

    // State and counters describe the word currently on dout; next_* is the following word.
    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg + 16'd1;
        line_cnt_next = line_cnt_reg;
        line_end      = (state_reg == TX_DATA) && (word_cnt_reg == LP_LAST);
        last_line     = (line_cnt_reg == LINES_LAST);
        case (state_reg)
            TX_IDLE: begin
                word_cnt_next = '0;
                line_cnt_next = '0;
                if (req_reg) state_next = TX_SYNC;
            end
            TX_SYNC: begin
                if (word_cnt_reg == SYNC_LAST) begin
                    state_next    = TX_DATA;
                    word_cnt_next = '0;
                end
            end
            TX_DATA: begin
                if (line_end) begin
                    word_cnt_next = '0;
                    if (GAP_WORDS > 0) begin
                        state_next = TX_GAP;
                    end else if (last_line) begin
                        state_next = TX_IDLE;
                    end else begin
                        line_cnt_next = line_cnt_reg + 16'd1;
                    end
                end
            end
            TX_GAP: begin
                if (word_cnt_reg == GAP_LAST) begin
                    word_cnt_next = '0;
                    if (last_line) begin
                        state_next = TX_IDLE;
                    end else begin
                        state_next    = TX_DATA;
                        line_cnt_next = line_cnt_reg + 16'd1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase

        pixel_next = s.valid ? s.pixel : '0;
        ready_set  = (state_next == TX_DATA);
`ifdef AFE2256_TX_TEST_PATTERN_EN
        if (tm_reg) pixel_next = line_cnt_next[0] ? COL_PATTERN : ROW_PATTERN;
        ready_set = (state_next == TX_DATA) && !test_mode;
`endif

        word_next = '0;
        if (state_next == TX_SYNC) begin
            word_next = {SYNC_PATTERN_HIGH, SYNC_PATTERN_LOW};
        end else if (state_next == TX_DATA) begin
            word_next = {pixel_next, align_vector(word_cnt_next == 16'd0,
                                                  word_cnt_next == LP_LAST,
                                                  word_cnt_next[7:0])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= TX_IDLE;
            word_cnt_reg   <= '0;
            line_cnt_reg   <= '0;
            req_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            dclk_reg       <= 1'b0;
            fclk_reg       <= 1'b0;
            s_ready_reg    <= 1'b0;
            line_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
`ifdef AFE2256_TX_TEST_PATTERN_EN
            tm_reg         <= 1'b0;
`endif
        end else begin
            dclk_reg       <= ~dclk_reg;
            line_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
            if (start && !busy_reg) begin
                req_reg  <= 1'b1;
                busy_reg <= 1'b1;
            end
            if (frame_done_reg) busy_reg <= 1'b0;
            // Decide one bit early so s_ready is a register valid exactly on bit 23.
            if (bit_cnt == 5'd22) begin
                s_ready_reg <= ready_set;
`ifdef AFE2256_TX_TEST_PATTERN_EN
                tm_reg      <= test_mode;
`endif
            end
            if (bit_cnt == 5'd11) fclk_reg <= 1'b0;
            if (word_end) begin
                state_reg      <= state_next;
                word_cnt_reg   <= word_cnt_next;
                line_cnt_reg   <= line_cnt_next;
                s_ready_reg    <= 1'b0;
                fclk_reg       <= (state_next != TX_IDLE);
                line_done_reg  <= line_end;
                frame_done_reg <= (state_reg != TX_IDLE) && (state_next == TX_IDLE);
                underflow_reg  <= s_ready_reg && !s.valid;
                if (state_reg == TX_IDLE) req_reg <= 1'b0;
            end
        end
    end

    afe2256_lvds_ser24 u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (state_next != TX_IDLE),
        .word     (word_next),
        .bit_cnt  (bit_cnt),
        .word_end (word_end),
        .dout     (dout)
    );

    assign s.ready    = s_ready_reg;
    assign dclk       = dclk_reg;
    assign fclk       = fclk_reg;
    assign busy       = busy_reg;
    assign line_done  = line_done_reg;
    assign frame_done = frame_done_reg;
    assign underflow  = underflow_reg;

endmodule
